// File: rtl/mult_issue_arb_if.sv
// Requester and multiplier-side signal bundle for mult_issue_arb.
// slave = arbiter view, master = client/multiplier view.
interface mult_issue_arb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i;
    logic [NUM_REQ-1:0]            resp_valid_o;
    logic [DATA_WIDTH-1:0]         resp_data_o;
    logic                          mult_start_o;
    logic [DATA_WIDTH-1:0]         mult_a_o;
    logic [DATA_WIDTH-1:0]         mult_b_o;
    logic [DATA_WIDTH-1:0]         mult_product_i;
    logic                          mult_done_i;

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, mult_product_i, mult_done_i,
        output req_ready_o, resp_valid_o, resp_data_o, mult_start_o, mult_a_o, mult_b_o
    );

    modport master (
        output req_valid_i, req_a_i, req_b_i, mult_product_i, mult_done_i,
        input  req_ready_o, resp_valid_o, resp_data_o, mult_start_o, mult_a_o, mult_b_o
    );
endinterface

// File: rtl/mult_issue_arb.sv
// Round-robin issue arbiter sharing one pipe_mult between NUM_REQ requesters.
// Optional MULT_ARB_STATS_EN adds saturating issue/stall counters.
module mult_issue_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_OUT    = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    mult_issue_arb_if.slave bus,
    output logic            idle_o,
    output logic            err_o
`ifdef MULT_ARB_STATS_EN
    ,
    output logic [31:0]     stat_issue_o,
    output logic [31:0]     stat_stall_o
`endif
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW  = $clog2(MAX_OUT + 1);

    logic [IDW-1:0]              rr_ptr;
    logic [IDW-1:0]              grant_id;
    logic                        grant_vld;
    logic [NUM_REQ-1:0]          grant;
    logic [NUM_REQ-1:0]          elig;
    logic [NUM_REQ-1:0]          resp_valid;
    logic [DATA_WIDTH-1:0]       resp_data;
    logic [CW-1:0]               out_cnt [NUM_REQ];
    logic                        mult_start_q;
    logic [DATA_WIDTH-1:0]       mult_a_q;
    logic [DATA_WIDTH-1:0]       mult_b_q;
    logic [IDW-1:0]              issue_id;
    logic [STAGES-1:0]           tag_v;
    logic [STAGES-1:0][IDW-1:0]  tag_id;

    always_comb begin
        resp_valid = '0;
        resp_data  = '0;
        if (bus.mult_done_i && tag_v[STAGES-1]) begin
            resp_valid[tag_id[STAGES-1]] = 1'b1;
            resp_data                    = bus.mult_product_i;
        end
    end

    // A response retiring this cycle frees its slot, so a requester at its
    // limit may be granted in the same cycle it receives a result.
    always_comb begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            elig[k] = bus.req_valid_i[k] & en_i &
                      ((out_cnt[k] < CW'(MAX_OUT)) | resp_valid[k]);
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        grant     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!grant_vld && elig[(32'(rr_ptr) + i) % NUM_REQ]) begin
                grant_vld = 1'b1;
                grant_id  = IDW'((32'(rr_ptr) + i) % NUM_REQ);
            end
        end
        if (grant_vld) grant[grant_id] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mult_start_q <= 1'b0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            issue_id     <= '0;
            rr_ptr       <= '0;
            tag_v        <= '0;
            tag_id       <= '0;
            err_o        <= 1'b0;
        end else begin
            mult_start_q <= grant_vld;
            if (grant_vld) begin
                mult_a_q <= bus.req_a_i[grant_id*DATA_WIDTH +: DATA_WIDTH];
                mult_b_q <= bus.req_b_i[grant_id*DATA_WIDTH +: DATA_WIDTH];
                issue_id <= grant_id;
                rr_ptr   <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
            // Head is loaded from the registered issue so the tail lines up
            // with done, STAGES cycles after mult_start_o.
            tag_v[0]  <= mult_start_q;
            tag_id[0] <= issue_id;
            for (int unsigned s = 1; s < STAGES; s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end
            if (bus.mult_done_i != tag_v[STAGES-1]) err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (rst_i)                          out_cnt[k] <= '0;
            else if (grant[k] && !resp_valid[k]) out_cnt[k] <= out_cnt[k] + 1'b1;
            else if (!grant[k] && resp_valid[k]) out_cnt[k] <= out_cnt[k] - 1'b1;
        end
    end

    always_comb begin
        idle_o = ~mult_start_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (out_cnt[k] != '0) idle_o = 1'b0;
        end
    end

`ifdef MULT_ARB_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_issue_o <= '0;
            stat_stall_o <= '0;
        end else begin
            if (grant_vld && stat_issue_o != '1) stat_issue_o <= stat_issue_o + 1'b1;
            if ((|bus.req_valid_i) && !grant_vld && stat_stall_o != '1)
                stat_stall_o <= stat_stall_o + 1'b1;
        end
    end
`endif

    assign bus.req_ready_o  = grant;
    assign bus.resp_valid_o = resp_valid;
    assign bus.resp_data_o  = resp_data;
    assign bus.mult_start_o = mult_start_q;
    assign bus.mult_a_o     = mult_a_q;
    assign bus.mult_b_o     = mult_b_q;
endmodule
